// File: rtl/data_pipe_arb_pkg.sv
// Shared types and sizing helpers for the data_pipe arbiters.
// Imported by the picker and the round-robin scheduler.
package data_pipe_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PATH,
    GRANT,
    RELEASE
  } arb_state_e;

  function automatic int nsize_of(input int num);
    if (num <= 2) return 1;
    else if (num <= 4) return 2;
    else if (num <= 8) return 3;
    else if (num <= 16) return 4;
    else return 5;
  endfunction

endpackage

// File: rtl/data_pipe_rr_picker.sv
// Round-robin pick: first requester after last_grant,
// wrapping, with the last-granted port as final candidate.
module data_pipe_rr_picker
  import data_pipe_arb_pkg::*;
#(
  parameter int NUM   = 8,
  parameter int NSIZE = nsize_of(NUM)
) (
  input  logic [NUM-1:0]   req,
  input  logic [NSIZE-1:0] last_grant,
  output logic [NSIZE-1:0] pick,
  output logic             pick_vld
);

  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = 1; i <= NUM; i++) begin
      for (int k = 0; k < NUM; k++) begin
        if (!pick_vld && req[k] &&
            ((int'(last_grant) + i) % NUM) == k) begin
          pick     = NSIZE'(k);
          pick_vld = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/data_pipe_m2s_rr_arbiter.sv
// Round-robin scheduler for sw/vld_sw of the NUM-to-1 pipe.
// sw only moves while vld_sw=0 and the pipe is drained.
module data_pipe_m2s_rr_arbiter
  import data_pipe_arb_pkg::*;
#(
  parameter int NUM       = 8,
  parameter int NSIZE     = nsize_of(NUM),
  parameter int MAX_BURST = 16
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic [NUM-1:0]   req,
  input  logic [NUM-1:0]   up_rdy,
  input  logic [NSIZE-1:0] curr_path,
  input  logic             down_vld,
  output logic [NSIZE-1:0] sw,
  output logic             vld_sw,
  output logic [NUM-1:0]   grant,
  output logic             busy
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam int NP = 1 << NSIZE;
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);
  localparam logic [NSIZE-1:0] LAST_PORT = NSIZE'(NUM - 1);

  arb_state_e cstate, nstate;

  logic [NSIZE-1:0] sw_nxt;
  logic [NSIZE-1:0] last_grant, last_nxt;
  logic             vld_nxt;
  logic             rel_wait, rel_wait_nxt;
  logic             cnt_clr;
  logic [CW-1:0]    beat_cnt;
  logic [NSIZE-1:0] pick;
  logic             pick_vld;
  logic             hs;
  logic [NP-1:0]    req_p;
  logic [NP-1:0]    rdy_p;
  logic [NP-1:0]    sel_oh;

  // Pad to a power of two so NSIZE-wide indices stay in range.
  assign req_p = NP'(req);
  assign rdy_p = NP'(up_rdy);
  assign hs    = req_p[curr_path] & rdy_p[curr_path] & clk_en;

  assign busy   = (cstate != IDLE);
  assign sel_oh = NP'(1) << sw;
  assign grant  = busy ? sel_oh[NUM-1:0] : '0;

  data_pipe_rr_picker #(
    .NUM  (NUM),
    .NSIZE(NSIZE)
  ) u_picker (
    .req       (req),
    .last_grant(last_grant),
    .pick      (pick),
    .pick_vld  (pick_vld)
  );

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      cstate     <= IDLE;
      sw         <= '0;
      vld_sw     <= 1'b0;
      last_grant <= LAST_PORT;
      rel_wait   <= 1'b0;
    end else if (clk_en) begin
      cstate     <= nstate;
      sw         <= sw_nxt;
      vld_sw     <= vld_nxt;
      last_grant <= last_nxt;
      rel_wait   <= rel_wait_nxt;
    end
  end

  always_comb begin
    nstate       = cstate;
    sw_nxt       = sw;
    vld_nxt      = vld_sw;
    last_nxt     = last_grant;
    rel_wait_nxt = 1'b0;
    cnt_clr      = 1'b0;
    unique case (cstate)
      IDLE: begin
        vld_nxt = 1'b0;
        if (pick_vld) begin
          sw_nxt = pick;
          nstate = WAIT_PATH;
        end
      end
      WAIT_PATH: begin
        vld_nxt = 1'b0;
        if (curr_path == sw && !down_vld) begin
          nstate  = GRANT;
          vld_nxt = 1'b1;
          cnt_clr = 1'b1;
        end
      end
      GRANT: begin
        vld_nxt = 1'b1;
        if ((hs && beat_cnt == LAST_BEAT) ||
            (!req_p[sw] && !hs)) begin
          nstate       = RELEASE;
          vld_nxt      = 1'b0;
          last_nxt     = sw;
          rel_wait_nxt = 1'b1;
        end
      end
      RELEASE: begin
        // First cycle is held: the pipe's ready is registered.
        vld_nxt = 1'b0;
        if (!rel_wait && !down_vld && !hs) begin
          if (pick_vld) begin
            sw_nxt = pick;
            nstate = WAIT_PATH;
          end else begin
            nstate = IDLE;
          end
        end
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (clk_en) begin
      if (cnt_clr) beat_cnt <= '0;
      else if (hs) beat_cnt <= beat_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_data_pipe_m2s_rr_arbiter.sv
// Directed bench: arbiter driving a small behavioural 4-to-1 pipe.
// Expected data/grant orders are hand-derived from the round-robin rules.
module tb_data_pipe_m2s_rr_arbiter;

  localparam int NUM = 4;
  localparam int NSIZE = 2;
  localparam int MAX_BURST = 4;

  logic             clock = 1'b0;
  logic             rst_n;
  logic             clk_en;
  logic [NUM-1:0]   req;
  logic [NUM-1:0]   up_rdy;
  logic [NSIZE-1:0] curr_path;
  logic             down_vld;
  logic [NSIZE-1:0] sw;
  logic             vld_sw;
  logic [NUM-1:0]   grant;
  logic             busy;

  logic       m_ready;
  logic [7:0] down_data;
  logic       hs_m;
  int rem[NUM];
  int sent[NUM];
  int out_q[$];
  int gq[$];
  int bq[$];
  int exp_q[$];
  int bcur;
  logic vld_prev;
  logic [NSIZE-1:0] sw_last;
  logic dv_last;
  int sw_viol = 0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  data_pipe_m2s_rr_arbiter #(
    .NUM(NUM), .NSIZE(NSIZE), .MAX_BURST(MAX_BURST)
  ) dut (
    .clock(clock), .rst_n(rst_n), .clk_en(clk_en),
    .req(req), .up_rdy(up_rdy), .curr_path(curr_path),
    .down_vld(down_vld), .sw(sw), .vld_sw(vld_sw),
    .grant(grant), .busy(busy)
  );

  always_comb begin
    req = '0;
    up_rdy = '0;
    for (int k = 0; k < NUM; k++) begin
      req[k] = (rem[k] != 0);
      up_rdy[k] = (curr_path == NSIZE'(k)) && vld_sw &&
                  (!down_vld || m_ready);
    end
  end

  assign hs_m = req[curr_path] & up_rdy[curr_path] & clk_en;

  // Behavioural interconnect: one-stage pipe, path latched while closed.
  always @(posedge clock) begin
    if (!rst_n) begin
      down_vld <= 1'b0;
      curr_path <= '0;
      down_data <= '0;
    end else if (clk_en) begin
      if (!vld_sw) curr_path <= sw;
      if (hs_m) begin
        down_vld <= 1'b1;
        down_data <= {curr_path, 6'(sent[curr_path])};
        sent[curr_path] <= sent[curr_path] + 1;
        rem[curr_path] <= rem[curr_path] - 1;
      end else if (m_ready) begin
        down_vld <= 1'b0;
      end
      if (down_vld && m_ready) out_q.push_back(int'(down_data));
    end
  end

  // Grant/burst log and sw-stability monitor.
  always @(posedge clock) begin
    if (!rst_n) begin
      vld_prev <= 1'b0;
      bcur <= 0;
      sw_last <= '0;
      dv_last <= 1'b0;
    end else if (clk_en) begin
      if (sw != sw_last && dv_last) sw_viol <= sw_viol + 1;
      sw_last <= sw;
      dv_last <= down_vld;
      if (vld_sw && !vld_prev) begin
        gq.push_back(int'(sw));
        bcur <= hs_m ? 1 : 0;
      end else if (hs_m) begin
        bcur <= bcur + 1;
      end
      if (!vld_sw && vld_prev) bq.push_back(bcur);
      vld_prev <= vld_sw;
    end
  end

  task automatic do_reset();
    @(negedge clock);
    rst_n = 1'b0;
    clk_en = 1'b1;
    m_ready = 1'b1;
    for (int k = 0; k < NUM; k++) begin
      rem[k] = 0;
      sent[k] = 0;
    end
    @(posedge clock);
    @(negedge clock);
    out_q.delete();
    gq.delete();
    bq.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input int budget, input bit rnd,
                           input string name);
    int n = 0;
    @(negedge clock);
    while ((busy || down_vld || (|req)) && n < budget) begin
      if (rnd) clk_en = 1'($urandom_range(0, 1));
      @(negedge clock);
      n++;
    end
    clk_en = 1'b1;
    vectors++;
    if (n >= budget) begin
      $display("FAIL %s: drain timeout after %0d cycles", name, n);
      miscompares++;
    end
  endtask

  task automatic wait_vld(input int budget, input string name);
    int n = 0;
    while (!vld_sw && n < budget) begin
      @(negedge clock);
      n++;
    end
    vectors++;
    if (!vld_sw) begin
      $display("FAIL %s: vld_sw never rose", name);
      miscompares++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clk_en = 1'b1;
    m_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    vectors++;
    if (sw !== 2'd0) begin
      $display("FAIL reset_sw: got %0d need 0", sw);
      miscompares++;
    end
    vectors++;
    if (vld_sw !== 1'b0) begin
      $display("FAIL reset_vld_sw: got %b need 0", vld_sw);
      miscompares++;
    end
    vectors++;
    if (busy !== 1'b0) begin
      $display("FAIL reset_busy: got %b need 0", busy);
      miscompares++;
    end
    vectors++;
    if (grant !== 4'b0000) begin
      $display("FAIL reset_grant: got %b need 0000", grant);
      miscompares++;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_port();
    do_reset();
    rem[2] = 3;
    @(negedge clock);
    vectors++;
    if (busy !== 1'b1 || sw !== 2'd2 || vld_sw !== 1'b0) begin
      $display("FAIL single_c1: busy=%b sw=%0d vld=%b need 1/2/0",
               busy, sw, vld_sw);
      miscompares++;
    end
    vectors++;
    if (grant !== 4'b0100) begin
      $display("FAIL single_grant: got %b need 0100", grant);
      miscompares++;
    end
    @(negedge clock);
    vectors++;
    if (vld_sw !== 1'b0) begin
      $display("FAIL single_c2_vld: got %b need 0", vld_sw);
      miscompares++;
    end
    @(negedge clock);
    vectors++;
    if (vld_sw !== 1'b1) begin
      $display("FAIL single_c3_vld: got %b need 1", vld_sw);
      miscompares++;
    end
    wait_done(100, 1'b0, "single_drain");
    exp_q = '{8'h80, 8'h81, 8'h82};
    vectors++;
    if (out_q.size() != 3) begin
      $display("FAIL single_count: got %0d need 3", out_q.size());
      miscompares++;
    end
    for (int i = 0; i < 3 && i < out_q.size(); i++) begin
      vectors++;
      if (out_q[i] !== exp_q[i]) begin
        $display("FAIL single_data[%0d]: got %h need %h",
                 i, out_q[i], exp_q[i]);
        miscompares++;
      end
    end
    vectors++;
    if (gq.size() != 1 || bq.size() != 1 ||
        (gq.size() == 1 && gq[0] != 2) ||
        (bq.size() == 1 && bq[0] != 3)) begin
      $display("FAIL single_grants: ng=%0d nb=%0d need one grant of 3 beats to port 2",
               gq.size(), bq.size());
      miscompares++;
    end
    vectors++;
    if (busy !== 1'b0 || vld_sw !== 1'b0) begin
      $display("FAIL single_idle: busy=%b vld=%b need 0/0", busy, vld_sw);
      miscompares++;
    end
  endtask

  task automatic run_three(input bit rnd, input string name);
    int ports[3] = '{0, 1, 3};
    int gexp[$];
    int bexp[$];
    do_reset();
    rem[0] = 10;
    rem[1] = 10;
    rem[3] = 10;
    wait_done(3000, rnd, name);
    exp_q.delete();
    for (int r = 0; r < 3; r++) begin
      for (int p = 0; p < 3; p++) begin
        gexp.push_back(ports[p]);
        bexp.push_back(r < 2 ? 4 : 2);
        for (int b = 0; b < (r < 2 ? 4 : 2); b++)
          exp_q.push_back(ports[p] * 64 + r * 4 + b);
      end
    end
    vectors++;
    if (out_q.size() != exp_q.size()) begin
      $display("FAIL %s_count: got %0d need %0d",
               name, out_q.size(), exp_q.size());
      miscompares++;
    end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      vectors++;
      if (out_q[i] !== exp_q[i]) begin
        $display("FAIL %s_data[%0d]: got %h need %h",
                 name, i, out_q[i], exp_q[i]);
        miscompares++;
      end
    end
    for (int i = 0; i < gexp.size(); i++) begin
      vectors++;
      if (i >= gq.size() || i >= bq.size() ||
          gq[i] != gexp[i] || bq[i] != bexp[i]) begin
        $display("FAIL %s_grant[%0d]: got port %0d len %0d need port %0d len %0d",
                 name, i, i < gq.size() ? gq[i] : -1,
                 i < bq.size() ? bq[i] : -1, gexp[i], bexp[i]);
        miscompares++;
      end
    end
  endtask

  task automatic test_interleave();
    run_three(1'b0, "rr");
  endtask

  task automatic test_burst_limit();
    int bexp[3] = '{4, 4, 1};
    do_reset();
    rem[1] = 9;
    wait_done(500, 1'b0, "limit_drain");
    vectors++;
    if (out_q.size() != 9) begin
      $display("FAIL limit_count: got %0d need 9", out_q.size());
      miscompares++;
    end
    for (int i = 0; i < 9 && i < out_q.size(); i++) begin
      vectors++;
      if (out_q[i] !== 64 + i) begin
        $display("FAIL limit_data[%0d]: got %h need %h",
                 i, out_q[i], 64 + i);
        miscompares++;
      end
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (i >= gq.size() || i >= bq.size() ||
          gq[i] != 1 || bq[i] != bexp[i]) begin
        $display("FAIL limit_burst[%0d]: got port %0d len %0d need port 1 len %0d",
                 i, i < gq.size() ? gq[i] : -1,
                 i < bq.size() ? bq[i] : -1, bexp[i]);
        miscompares++;
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    m_ready = 1'b0;
    rem[0] = 2;
    rem[2] = 2;
    repeat (12) @(negedge clock);
    vectors++;
    if (sw !== 2'd0 || vld_sw !== 1'b1 || down_vld !== 1'b1) begin
      $display("FAIL stall_hold: sw=%0d vld=%b dv=%b need 0/1/1",
               sw, vld_sw, down_vld);
      miscompares++;
    end
    vectors++;
    if (out_q.size() != 0) begin
      $display("FAIL stall_out: got %0d beats need 0", out_q.size());
      miscompares++;
    end
    m_ready = 1'b1;
    wait_done(500, 1'b0, "stall_drain");
    exp_q = '{8'h00, 8'h01, 8'h80, 8'h81};
    vectors++;
    if (out_q.size() != 4) begin
      $display("FAIL stall_count: got %0d need 4", out_q.size());
      miscompares++;
    end
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      vectors++;
      if (out_q[i] !== exp_q[i]) begin
        $display("FAIL stall_data[%0d]: got %h need %h",
                 i, out_q[i], exp_q[i]);
        miscompares++;
      end
    end
    vectors++;
    if (sw_viol != 0) begin
      $display("FAIL sw_stable: got %0d changes with pipe full need 0",
               sw_viol);
      miscompares++;
    end
  endtask

  task automatic test_clk_en();
    int osz;
    do_reset();
    rem[1] = 5;
    wait_vld(20, "freeze_grant");
    osz = out_q.size();
    clk_en = 1'b0;
    repeat (4) @(negedge clock);
    vectors++;
    if (vld_sw !== 1'b1 || sw !== 2'd1 || busy !== 1'b1) begin
      $display("FAIL freeze_state: vld=%b sw=%0d busy=%b need 1/1/1",
               vld_sw, sw, busy);
      miscompares++;
    end
    vectors++;
    if (out_q.size() != osz) begin
      $display("FAIL freeze_out: got %0d beats need %0d",
               out_q.size(), osz);
      miscompares++;
    end
    clk_en = 1'b1;
    wait_done(500, 1'b0, "freeze_drain");
    vectors++;
    if (bq.size() != 2 || (bq.size() == 2 && (bq[0] != 4 || bq[1] != 1))) begin
      $display("FAIL freeze_bursts: got %0d bursts need 4,1", bq.size());
      miscompares++;
    end
    run_three(1'b1, "rr_gated");
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    rem[0] = 10;
    wait_vld(20, "rst_grant");
    repeat (2) @(negedge clock);
    rst_n = 1'b0;
    for (int k = 0; k < NUM; k++) rem[k] = 0;
    @(negedge clock);
    vectors++;
    if (vld_sw !== 1'b0 || sw !== 2'd0 || busy !== 1'b0) begin
      $display("FAIL rst_mid: vld=%b sw=%0d busy=%b need 0/0/0",
               vld_sw, sw, busy);
      miscompares++;
    end
    vectors++;
    if (grant !== 4'b0000) begin
      $display("FAIL rst_mid_grant: got %b need 0000", grant);
      miscompares++;
    end
    for (int k = 0; k < NUM; k++) sent[k] = 0;
    out_q.delete();
    gq.delete();
    bq.delete();
    rst_n = 1'b1;
    rem[3] = 2;
    wait_done(200, 1'b0, "rst_drain");
    vectors++;
    if (gq.size() == 0 || gq[0] != 3) begin
      $display("FAIL rst_first_grant: got %0d need 3",
               gq.size() ? gq[0] : -1);
      miscompares++;
    end
    exp_q = '{8'hC0, 8'hC1};
    vectors++;
    if (out_q.size() != 2 ||
        (out_q.size() == 2 && (out_q[0] != exp_q[0] || out_q[1] != exp_q[1]))) begin
      $display("FAIL rst_data: got %0d beats need c0,c1", out_q.size());
      miscompares++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clk_en = 1'b1;
    m_ready = 1'b1;
    for (int k = 0; k < NUM; k++) begin
      rem[k] = 0;
      sent[k] = 0;
    end
    test_reset();
    test_single_port();
    test_interleave();
    test_burst_limit();
    test_backpressure();
    test_clk_en();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
